// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, counter sizing
// and the saturating loss-counter increment.
package pll_rst_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LOSS_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_e;

    // Counter wide enough to hold its own limit value.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return 32'($clog2(limit)) + 32'd1;
    endfunction

    function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] cnt);
        return (cnt == {LOSS_W{1'b1}}) ? cnt : cnt + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into the clk domain.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin : sync_reg
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses pll_rst, qualifies a stable lock, releases sys_rst,
// retries on lock timeout and latches a fault once the retry budget is spent.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRY           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              restart,
    output logic              pll_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic              fault,
    output logic [LOSS_W-1:0] lock_loss_cnt,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned HOLD_W  = cnt_width(RST_HOLD_CYCLES);
    localparam int unsigned STAB_W  = cnt_width(LOCK_STABLE_CYCLES);
    localparam int unsigned TMO_W   = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);
    // The WAIT_LOCK sample that enters STABLE is the first of the qualifying run.
    localparam int unsigned STAB_LAST = (LOCK_STABLE_CYCLES > 32'd1) ? LOCK_STABLE_CYCLES - 32'd2 : 32'd0;

    seq_state_e           state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [STAB_W-1:0]    stab_q, stab_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [LOSS_W-1:0]    loss_q, loss_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 sys_rst_q, sys_rst_d;
    logic                 ready_q, ready_d;
    logic                 fault_q, fault_d;
    logic                 lock_s;
    logic                 run_ok;
    logic                 tmo_hit;

    sync_2ff #(
        .RST_VAL(1'b0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_s)
    );

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q   <= ST_PLL_RST;
            hold_q    <= '0;
            stab_q    <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stab_q    <= stab_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        hold_d  = hold_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        run_ok  = (state_q == ST_STABLE) && lock_s && (stab_q == STAB_W'(STAB_LAST));
        tmo_hit = (tmo_q == TMO_W'(LOCK_TIMEOUT_CYCLES - 32'd1));

        if (restart) begin
            // A lock drop coinciding with restart is still counted.
            if ((state_q == ST_RUN) && !lock_s) begin
                loss_d = loss_sat_inc(loss_q);
            end
            state_d = ST_PLL_RST;
            hold_d  = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 32'd1)) begin
                        state_d = ST_WAIT_LOCK;
                        hold_d  = '0;
                        tmo_d   = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (run_ok) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (tmo_hit) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = (retry_d == RETRY_W'(MAX_RETRY)) ? ST_FAULT : ST_PLL_RST;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                        if (state_q == ST_WAIT_LOCK) begin
                            if (lock_s) begin
                                state_d = ST_STABLE;
                                stab_d  = '0;
                            end
                        end else if (!lock_s) begin
                            state_d = ST_WAIT_LOCK;
                        end else begin
                            stab_d = stab_q + STAB_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        loss_d  = loss_sat_inc(loss_q);
                        state_d = ST_PLL_RST;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_PLL_RST;
                    hold_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin : output_dec
        pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
        fault_d   = (state_d == ST_FAULT);
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule
